pc_fetch_unit: RTL

- Consumer end of the branch-resolution interface: owns the program counter and the IF/ID pipeline register.
- Accepts the redirect request (pc_sel, branch_pc) from the branch unit and the stall request from the hazard unit.
- Drives the instruction-memory address and captures the fetched instruction.
- Decodes the halt encoding (pc_sel=1, branch_pc=32'hFFFFFFFF) into a terminal HALTED state.

---
 rtl/pc_fetch_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program counter and IF/ID register with redirect, stall and halt.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
   parameter int          WIDTH     = 9,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             pc_sel,
   input  logic [31:0]      branch_pc,
   input  logic [31:0]      instr_rdata,
   output logic [WIDTH-1:0] imem_addr,
   output logic [WIDTH-1:0] pc_plus_4,
   output logic [WIDTH-1:0] if_id_pc,
   output logic [31:0]      if_id_instr,
   output logic             if_id_valid,
   output logic             halted,
   output logic             misaligned,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam logic [0:0]       c_ST_RUN    = 1'b0;
   localparam logic [0:0]       c_ST_HALTED = 1'b1;
   localparam logic [31:0]      c_HALT_PC   = 32'hFFFF_FFFF;
   localparam logic [WIDTH-1:0] c_PC_STEP   = WIDTH'(4);
   localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_if_id_pc;
   logic [31:0]      r_if_id_instr;
   logic             r_if_id_valid;
   logic             r_misaligned;
   logic [CNT_W-1:0] r_redirect_cnt;

   logic w_halt_req;
   logic w_do_halt;
   logic w_do_redir;
   logic w_do_adv;

   assign w_halt_req = pc_sel && (branch_pc == c_HALT_PC);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == c_ST_RUN && w_halt_req) begin
         w_state_nxt = c_ST_HALTED;
      end
   end

   // Event priority in RUN: halt > redirect > stall > advance; HALTED ignores all.
   always_comb begin
      w_do_halt  = 1'b0;
      w_do_redir = 1'b0;
      w_do_adv   = 1'b0;
      if (r_state == c_ST_RUN) begin
         if (w_halt_req) begin
            w_do_halt = 1'b1;
         end else if (pc_sel) begin
            w_do_redir = 1'b1;
         end else if (!stall) begin
            w_do_adv = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc           <= '0;
         r_if_id_pc     <= '0;
         r_if_id_instr  <= NOP_INSTR;
         r_if_id_valid  <= 1'b0;
         r_misaligned   <= 1'b0;
         r_redirect_cnt <= '0;
      end else begin
         // The word fetched in a halt/redirect cycle is wrong-path: squash it.
         if (w_do_halt || w_do_redir) begin
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
         end
         if (w_do_redir) begin
            r_pc <= {branch_pc[WIDTH-1:2], 2'b00};
            if (branch_pc[1:0] != 2'b00) begin
               r_misaligned <= 1'b1;
            end
            if (r_redirect_cnt != c_CNT_MAX) begin
               r_redirect_cnt <= r_redirect_cnt + c_CNT_ONE;
            end
         end
         if (w_do_adv) begin
            r_pc          <= r_pc + c_PC_STEP;
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= instr_rdata;
            r_if_id_valid <= 1'b1;
         end
      end
   end

   assign imem_addr    = r_pc;
   assign pc_plus_4    = r_pc + c_PC_STEP;
   assign if_id_pc     = r_if_id_pc;
   assign if_id_instr  = r_if_id_instr;
   assign if_id_valid  = r_if_id_valid;
   assign halted       = (r_state == c_ST_HALTED);
   assign misaligned   = r_misaligned;
   assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire
